// File: rtl/hazard_forward_scoreboard_pkg.sv
// Shared constants and helpers for the decode-stage hazard/forwarding unit.
// Register indices are 5 bits; x0 is hardwired zero and never forwarded or tracked.
package hazard_forward_scoreboard_pkg;

    localparam int         REG_W    = 5;
    localparam logic       ENABLE   = 1'b1;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef logic [REG_W-1:0] reg_idx_t;

    // x0 never matches anything, so a write "to x0" can never shadow a read of x0.
    function automatic logic idx_match(input reg_idx_t a, input reg_idx_t b);
        return (a == b) && (a != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_forward_scoreboard_operand_forward_mux.sv
// Per-read-port priority mux: youngest enabled stage, then completion bus, then register file.
// Purely combinational; also reports whether the selected stage still holds an unresolved load.
module operand_forward_mux
    import hazard_forward_scoreboard_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic [4:0]              i_src_index,
    input  logic [XLEN-1:0]         i_rf_data,
    input  logic [NUM_FWD*5-1:0]    i_fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0] i_fwd_data,
    input  logic [NUM_FWD-1:0]      i_fwd_enable,
    input  logic [NUM_FWD-1:0]      i_fwd_is_load,
    input  logic                    i_complete_valid,
    input  logic [4:0]              i_complete_rd,
    input  logic [XLEN-1:0]         i_complete_data,
    output logic [XLEN-1:0]         o_data,
    output logic                    o_hit,
    output logic                    o_load_use,
    output logic                    o_stage_match,
    output logic                    o_comp_match
);

    always_comb begin
        o_data        = i_rf_data;
        o_hit         = 1'b0;
        o_load_use    = 1'b0;
        o_stage_match = 1'b0;
        o_comp_match  = i_complete_valid && idx_match(i_src_index, i_complete_rd);
        if (o_comp_match) begin
            o_data = i_complete_data;
            o_hit  = 1'b1;
        end
        // Walk oldest to youngest so the lowest-index (youngest) match wins.
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if ((i_fwd_enable[k] == ENABLE) && idx_match(i_src_index, i_fwd_rd[k*5 +: 5])) begin
                o_data        = i_fwd_data[k*XLEN +: XLEN];
                o_hit         = 1'b1;
                o_load_use    = i_fwd_is_load[k];
                o_stage_match = 1'b1;
            end
        end
        if (i_src_index == REG_ZERO) begin
            o_data = '0;
            o_hit  = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_forward_scoreboard.sv
// Decode-stage operand forwarding plus a pending-write scoreboard for long-latency ops.
// Stall is combinational; scoreboard, outstanding count, stall counter and error flag update on the rising edge.
module hazard_forward_scoreboard
    import hazard_forward_scoreboard_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int NUM_READ        = 2,
    parameter int NUM_FWD         = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STALL_CNT_W     = 16,
    localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_READ*5-1:0]    i_src_index,
    input  logic [NUM_READ*XLEN-1:0] i_rf_data,
    input  logic [NUM_FWD*5-1:0]     i_fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]  i_fwd_data,
    input  logic [NUM_FWD-1:0]       i_fwd_enable,
    input  logic [NUM_FWD-1:0]       i_fwd_is_load,
    input  logic                     i_issue_valid,
    input  logic [4:0]               i_issue_rd,
    input  logic                     i_flush,
    input  logic                     i_complete_valid,
    input  logic [4:0]               i_complete_rd,
    input  logic [XLEN-1:0]          i_complete_data,
    output logic [NUM_READ*XLEN-1:0] o_operand_data,
    output logic [NUM_READ-1:0]      o_forward_hit,
    output logic                     o_stall,
    output logic [31:0]              o_pending_vector,
    output logic [OUT_W-1:0]         o_outstanding,
    output logic [STALL_CNT_W-1:0]   o_stall_count,
    output logic                     o_sb_error
);

    logic [31:0]            r_pending;
    logic [OUT_W-1:0]       r_outstanding;
    logic [STALL_CNT_W-1:0] r_stall_count;
    logic                   r_sb_error;

    logic [NUM_READ-1:0] w_load_use;
    logic [NUM_READ-1:0] w_stage_match;
    logic [NUM_READ-1:0] w_comp_match;
    logic [NUM_READ-1:0] w_raw_pend;
    logic                w_issue_req;
    logic                w_waw;
    logic                w_full;
    logic                w_do_issue;
    logic                w_do_comp;
    logic                w_comp_orphan;
    logic [31:0]         w_pending_nxt;

    for (genvar p = 0; p < NUM_READ; p++) begin : g_port
        operand_forward_mux #(
            .XLEN    (XLEN),
            .NUM_FWD (NUM_FWD)
        ) u_mux (
            .i_src_index      (i_src_index[p*5 +: 5]),
            .i_rf_data        (i_rf_data[p*XLEN +: XLEN]),
            .i_fwd_rd         (i_fwd_rd),
            .i_fwd_data       (i_fwd_data),
            .i_fwd_enable     (i_fwd_enable),
            .i_fwd_is_load    (i_fwd_is_load),
            .i_complete_valid (i_complete_valid),
            .i_complete_rd    (i_complete_rd),
            .i_complete_data  (i_complete_data),
            .o_data           (o_operand_data[p*XLEN +: XLEN]),
            .o_hit            (o_forward_hit[p]),
            .o_load_use       (w_load_use[p]),
            .o_stage_match    (w_stage_match[p]),
            .o_comp_match     (w_comp_match[p])
        );
        // A pending register is only safe to read if some bypass path supplies it this cycle.
        assign w_raw_pend[p] = r_pending[i_src_index[p*5 +: 5]] && !w_stage_match[p] && !w_comp_match[p];
    end

    assign w_issue_req = i_issue_valid && !i_flush;
    assign w_waw       = w_issue_req && (i_issue_rd != REG_ZERO) && r_pending[i_issue_rd]
                         && !(i_complete_valid && (i_complete_rd == i_issue_rd));
    assign w_full      = w_issue_req && (r_outstanding == OUT_W'(MAX_OUTSTANDING)) && !i_complete_valid;
    assign o_stall     = (|w_load_use) || (|w_raw_pend) || w_waw || w_full;

    assign w_do_issue    = w_issue_req && !o_stall && (i_issue_rd != REG_ZERO);
    assign w_do_comp     = i_complete_valid && (i_complete_rd != REG_ZERO) && r_pending[i_complete_rd];
    assign w_comp_orphan = i_complete_valid && (i_complete_rd != REG_ZERO) && !r_pending[i_complete_rd];

    // Clear before set: a same-cycle complete and re-issue to one rd leaves it pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_do_comp)  w_pending_nxt[i_complete_rd] = 1'b0;
        if (w_do_issue) w_pending_nxt[i_issue_rd]    = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pending     <= '0;
            r_outstanding <= '0;
            r_stall_count <= '0;
            r_sb_error    <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            case ({w_do_issue, w_do_comp})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
            if (o_stall && (r_stall_count != '1)) r_stall_count <= r_stall_count + 1'b1;
            if (w_comp_orphan) r_sb_error <= 1'b1;
        end
    end

    assign o_pending_vector = r_pending;
    assign o_outstanding    = r_outstanding;
    assign o_stall_count    = r_stall_count;
    assign o_sb_error       = r_sb_error;

endmodule

// File: tb/tb_hazard_forward_scoreboard.sv
// Directed bench for hazard_forward_scoreboard; a 4-bit stall counter makes saturation reachable.
module tb_hazard_forward_scoreboard;
    localparam int XLEN = 32, NR = 2, NF = 2, MAXO = 4, SCW = 4;
    localparam int OW = $clog2(MAXO + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR*5-1:0]   src_index;
    logic [NR*XLEN-1:0] rf_data;
    logic [NF*5-1:0]   fwd_rd;
    logic [NF*XLEN-1:0] fwd_data;
    logic [NF-1:0]     fwd_enable, fwd_is_load;
    logic              issue_valid, flush, complete_valid;
    logic [4:0]        issue_rd, complete_rd;
    logic [XLEN-1:0]   complete_data;
    logic [NR*XLEN-1:0] operand_data;
    logic [NR-1:0]     forward_hit;
    logic              stall, sb_error;
    logic [31:0]       pending_vector;
    logic [OW-1:0]     outstanding;
    logic [SCW-1:0]    stall_count;

    int checks = 0;
    int errors = 0;
    int exp_sc = 0;

    hazard_forward_scoreboard #(
        .XLEN(XLEN), .NUM_READ(NR), .NUM_FWD(NF), .MAX_OUTSTANDING(MAXO), .STALL_CNT_W(SCW)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_src_index(src_index), .i_rf_data(rf_data),
        .i_fwd_rd(fwd_rd), .i_fwd_data(fwd_data), .i_fwd_enable(fwd_enable),
        .i_fwd_is_load(fwd_is_load), .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
        .i_flush(flush), .i_complete_valid(complete_valid), .i_complete_rd(complete_rd),
        .i_complete_data(complete_data), .o_operand_data(operand_data),
        .o_forward_hit(forward_hit), .o_stall(stall), .o_pending_vector(pending_vector),
        .o_outstanding(outstanding), .o_stall_count(stall_count), .o_sb_error(sb_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        src_index = '0; rf_data = '0; fwd_rd = '0; fwd_data = '0;
        fwd_enable = '0; fwd_is_load = '0; issue_valid = 0; issue_rd = '0;
        flush = 0; complete_valid = 0; complete_rd = '0; complete_data = '0;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pend, input int outs);
        chk({tag, "_pending"}, 64'(pending_vector), 64'(pend));
        chk({tag, "_outstanding"}, 64'(outstanding), 64'(outs));
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #2;
        chk("rst_pending", 64'(pending_vector), 64'h0);
        chk("rst_outstanding", 64'(outstanding), 64'h0);
        chk("rst_stall_count", 64'(stall_count), 64'h0);
        chk("rst_sb_error", 64'(sb_error), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Forwarding priority and x0 handling
        src_index = {5'd3, 5'd5};
        rf_data   = {32'h0000_0033, 32'h0000_0011};
        fwd_rd    = {5'd5, 5'd5};
        fwd_data  = {32'hBBBB_0000, 32'hAAAA_0000};
        fwd_enable = 2'b11;
        #1;
        chk("prio_op0", 64'(operand_data[31:0]), 64'hAAAA_0000);
        chk("prio_hit", 64'(forward_hit), 64'b01);
        chk("prio_stall", 64'(stall), 64'h0);
        chk("prio_op1_rf", 64'(operand_data[63:32]), 64'h33);
        fwd_enable = 2'b10;
        #1;
        chk("stage1_op0", 64'(operand_data[31:0]), 64'hBBBB_0000);
        fwd_enable = 2'b00; complete_valid = 1; complete_rd = 5'd5; complete_data = 32'hC0C0;
        #1;
        chk("comp_bus_op0", 64'(operand_data[31:0]), 64'hC0C0);
        chk("comp_bus_hit", 64'(forward_hit), 64'b01);
        complete_valid = 0; fwd_rd = {5'd5, 5'd0}; fwd_enable = 2'b01; src_index = {5'd3, 5'd0};
        #1;
        chk("x0_op0", 64'(operand_data[31:0]), 64'h0);
        chk("x0_hit", 64'(forward_hit), 64'b00);
        clear_inputs();

        // Load-use
        src_index = {5'd0, 5'd7}; fwd_rd = {5'd0, 5'd7}; fwd_enable = 2'b01; fwd_is_load = 2'b01;
        #1;
        chk("lu_stall", 64'(stall), 64'h1);
        tick(); exp_sc++;
        chk("lu_count", 64'(stall_count), 64'(exp_sc));
        fwd_is_load = 2'b00; fwd_data = {32'h0, 32'h1234};
        #1;
        chk("lu_op0", 64'(operand_data[31:0]), 64'h1234);
        chk("lu_release", 64'(stall), 64'h0);
        tick();
        clear_inputs();

        // RAW on a pending long op
        issue_valid = 1; issue_rd = 5'd9;
        #1;
        chk("issue9_stall", 64'(stall), 64'h0);
        tick();
        issue_valid = 0;
        chk_state("issue9", 32'h0000_0200, 1);
        src_index = {5'd0, 5'd9};
        #1;
        chk("raw_stall", 64'(stall), 64'h1);
        tick(); exp_sc++;
        chk("raw_count", 64'(stall_count), 64'(exp_sc));
        complete_valid = 1; complete_rd = 5'd9; complete_data = 32'h55;
        #1;
        chk("raw_comp_op0", 64'(operand_data[31:0]), 64'h55);
        chk("raw_comp_stall", 64'(stall), 64'h0);
        tick();
        clear_inputs();
        chk_state("comp9", 32'h0, 0);
        chk("comp9_err", 64'(sb_error), 64'h0);

        // Outstanding limit and WAW
        for (int r = 1; r <= 4; r++) begin
            issue_valid = 1; issue_rd = 5'(r);
            tick();
        end
        chk_state("fill", 32'h0000_001E, 4);
        issue_rd = 5'd5;
        #1;
        chk("full_stall", 64'(stall), 64'h1);
        tick(); exp_sc++;
        chk_state("full_hold", 32'h0000_001E, 4);
        issue_rd = 5'd2; complete_valid = 1; complete_rd = 5'd2;
        #1;
        chk("waw_comp_stall", 64'(stall), 64'h0);
        tick();
        chk_state("waw_comp", 32'h0000_001E, 4);
        complete_valid = 0; flush = 1;
        #1;
        chk("flush_stall", 64'(stall), 64'h0);
        tick();
        chk_state("flush", 32'h0000_001E, 4);
        flush = 0; issue_valid = 0; complete_valid = 1; complete_rd = 5'd4;
        tick();
        chk_state("comp4", 32'h0000_000E, 3);
        complete_valid = 0; issue_valid = 1; issue_rd = 5'd2;
        #1;
        chk("waw_stall", 64'(stall), 64'h1);
        tick(); exp_sc++;
        chk_state("waw_hold", 32'h0000_000E, 3);
        chk("waw_count", 64'(stall_count), 64'(exp_sc));

        // Orphan completion, x0 issue, counter saturation
        issue_valid = 0; complete_valid = 1; complete_rd = 5'd12;
        tick();
        chk("orphan_err", 64'(sb_error), 64'h1);
        chk_state("orphan", 32'h0000_000E, 3);
        complete_valid = 0; issue_valid = 1; issue_rd = 5'd0;
        tick();
        chk("err_sticky", 64'(sb_error), 64'h1);
        chk_state("issue_x0", 32'h0000_000E, 3);
        issue_valid = 0; src_index = {5'd0, 5'd1};
        repeat (11) begin
            tick(); exp_sc++;
        end
        chk("sat_reach", 64'(stall_count), 64'hF);
        repeat (3) tick();
        chk("sat_hold", 64'(stall_count), 64'hF);
        clear_inputs();

        // Asynchronous reset mid-cycle, then a stale completion
        #3;
        rst_n = 1'b0;
        #1;
        chk_state("arst", 32'h0, 0);
        chk("arst_count", 64'(stall_count), 64'h0);
        chk("arst_err", 64'(sb_error), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        complete_valid = 1; complete_rd = 5'd1;
        tick();
        chk("stale_comp_err", 64'(sb_error), 64'h1);
        chk_state("stale_comp", 32'h0, 0);
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
